// File: rtl/uart_rx_fsm.sv
// UART receive controller: start detect, oversampled 3-point majority vote, bit sequencing, frame qualification.
// Latency: all outputs registered; data_valid / stop_err pulse one cycle after the stop bit's last oversample.
// No backpressure: enables and status are single-cycle pulses; downstream must accept them when issued.
module uart_rx_fsm #(
    parameter int PRESCALE_WIDTH = 6
) (
    input  logic                      CLK,
    input  logic                      RST,
    input  logic                      RX_IN,
    input  logic [PRESCALE_WIDTH-1:0] PRESCALE,
    input  logic                      PAR_EN,
    input  logic                      parity_err,
    output logic [3:0]                bit_cnt,
    output logic                      sampled_data,
    output logic                      parity_checker_enable,
    output logic                      deser_enable,
    output logic                      data_valid,
    output logic                      stop_err,
    output logic                      strt_glitch
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;

    state_t                    state_q, state_d;
    logic [PRESCALE_WIDTH-1:0] edge_cnt_q, edge_cnt_d;
    logic [3:0]                bit_cnt_q, bit_cnt_d;
    logic [PRESCALE_WIDTH-1:0] prescale_q, prescale_d;
    logic                      par_en_q, par_en_d;
    logic                      smp0_q, smp0_d;
    logic                      smp1_q, smp1_d;
    logic                      sampled_q, sampled_d;
    logic                      par_chk_en_q, par_chk_en_d;
    logic                      deser_en_q, deser_en_d;
    logic                      data_valid_q, data_valid_d;
    logic                      stop_err_q, stop_err_d;
    logic                      strt_glitch_q, strt_glitch_d;

    // Oversample position decodes, all relative to the prescale latched for this frame.
    logic [PRESCALE_WIDTH-1:0] half;
    logic                      in_frame;
    logic                      edge_last;
    logic                      edge_pre;
    logic                      edge_s0;
    logic                      edge_s1;
    logic                      edge_s2;
    logic                      latch_cfg;

    assign half      = prescale_q >> 1;
    assign in_frame  = (state_q != IDLE);
    assign edge_last = in_frame && (edge_cnt_q == prescale_q - PRESCALE_WIDTH'(1));
    assign edge_pre  = in_frame && (edge_cnt_q == prescale_q - PRESCALE_WIDTH'(2));
    assign edge_s0   = in_frame && (edge_cnt_q == half - PRESCALE_WIDTH'(2));
    assign edge_s1   = in_frame && (edge_cnt_q == half - PRESCALE_WIDTH'(1));
    assign edge_s2   = in_frame && (edge_cnt_q == half);
    // A new frame begins either from idle or straight out of a stop bit (back-to-back frames).
    assign latch_cfg = (state_t'(state_d) == START) && (state_q == IDLE || state_q == STOP);

    // State and datapath registers, async reset discards any frame in progress.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q       <= IDLE;
            edge_cnt_q    <= '0;
            bit_cnt_q     <= '0;
            prescale_q    <= PRESCALE_WIDTH'(8);
            par_en_q      <= 1'b0;
            smp0_q        <= 1'b1;
            smp1_q        <= 1'b1;
            sampled_q     <= 1'b1;
            par_chk_en_q  <= 1'b0;
            deser_en_q    <= 1'b0;
            data_valid_q  <= 1'b0;
            stop_err_q    <= 1'b0;
            strt_glitch_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            edge_cnt_q    <= edge_cnt_d;
            bit_cnt_q     <= bit_cnt_d;
            prescale_q    <= prescale_d;
            par_en_q      <= par_en_d;
            smp0_q        <= smp0_d;
            smp1_q        <= smp1_d;
            sampled_q     <= sampled_d;
            par_chk_en_q  <= par_chk_en_d;
            deser_en_q    <= deser_en_d;
            data_valid_q  <= data_valid_d;
            stop_err_q    <= stop_err_d;
            strt_glitch_q <= strt_glitch_d;
        end
    end

    // Next-state: transitions only on the end-of-bit oversample, except the idle start detect.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (!RX_IN) state_d = START;
            end
            START: begin
                if (edge_last) state_d = sampled_q ? IDLE : DATA;
            end
            DATA: begin
                if (edge_last && bit_cnt_q == 4'd8) state_d = par_en_q ? PARITY : STOP;
            end
            PARITY: begin
                if (edge_last) state_d = STOP;
            end
            STOP: begin
                if (edge_last) state_d = RX_IN ? IDLE : START;
            end
            default: state_d = IDLE;
        endcase
    end

    // Counters, majority vote, per-bit enables and frame status pulses.
    always_comb begin
        edge_cnt_d    = edge_cnt_q;
        bit_cnt_d     = bit_cnt_q;
        prescale_d    = latch_cfg ? PRESCALE : prescale_q;
        par_en_d      = latch_cfg ? PAR_EN : par_en_q;
        smp0_d        = edge_s0 ? RX_IN : smp0_q;
        smp1_d        = edge_s1 ? RX_IN : smp1_q;
        sampled_d     = sampled_q;
        par_chk_en_d  = 1'b0;
        deser_en_d    = 1'b0;
        data_valid_d  = 1'b0;
        stop_err_d    = 1'b0;
        strt_glitch_d = 1'b0;

        if (!in_frame) begin
            edge_cnt_d = '0;
            bit_cnt_d  = '0;
        end else if (edge_last) begin
            edge_cnt_d = '0;
            // Leaving the frame (to idle or a fresh start) restarts bit numbering at the start bit.
            if (state_d == IDLE || state_d == START) bit_cnt_d = '0;
            else                                     bit_cnt_d = bit_cnt_q + 4'd1;
        end else begin
            edge_cnt_d = edge_cnt_q + PRESCALE_WIDTH'(1);
        end

        // Third sample comes straight from the line; the vote lands the cycle after.
        if (edge_s2) begin
            sampled_d = (smp0_q & smp1_q) | (smp0_q & RX_IN) | (smp1_q & RX_IN);
        end

        // Registered one cycle early so the pulse coincides with the end-of-bit cycle.
        if (edge_pre) begin
            deser_en_d   = (state_q == DATA);
            par_chk_en_d = par_en_q && (state_q == DATA || state_q == PARITY);
        end

        if (edge_last) begin
            strt_glitch_d = (state_q == START) && sampled_q;
            data_valid_d  = (state_q == STOP) && sampled_q && !(par_en_q && parity_err);
            stop_err_d    = (state_q == STOP) && !sampled_q;
        end
    end

    assign bit_cnt               = bit_cnt_q;
    assign sampled_data          = sampled_q;
    assign parity_checker_enable = par_chk_en_q;
    assign deser_enable          = deser_en_q;
    assign data_valid            = data_valid_q;
    assign stop_err              = stop_err_q;
    assign strt_glitch           = strt_glitch_q;

endmodule

// File: tb/tb_uart_rx_fsm.sv
// Bench for uart_rx_fsm: drives serial frames and compares every output pulse against a frame-level event model.
// Latency: expected pulse cycles derived from the frame start cycle and the prescale.
// No backpressure: all DUT pulses are recorded by a monitor and matched in order.
module tb_uart_rx_fsm;
    localparam int PW = 6;

    logic          CLK = 1'b0;
    logic          RST;
    logic          RX_IN;
    logic [PW-1:0] PRESCALE;
    logic          PAR_EN;
    logic          parity_err;
    logic [3:0]    bit_cnt;
    logic          sampled_data;
    logic          parity_checker_enable;
    logic          deser_enable;
    logic          data_valid;
    logic          stop_err;
    logic          strt_glitch;

    uart_rx_fsm #(.PRESCALE_WIDTH(PW)) dut (
        .CLK                   (CLK),
        .RST                   (RST),
        .RX_IN                 (RX_IN),
        .PRESCALE              (PRESCALE),
        .PAR_EN                (PAR_EN),
        .parity_err            (parity_err),
        .bit_cnt               (bit_cnt),
        .sampled_data          (sampled_data),
        .parity_checker_enable (parity_checker_enable),
        .deser_enable          (deser_enable),
        .data_valid            (data_valid),
        .stop_err              (stop_err),
        .strt_glitch           (strt_glitch)
    );

    always #5 CLK = ~CLK;

    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    int n_checks = 0;
    int n_errors = 0;

    // kind: 0 deser_enable, 1 parity_checker_enable, 2 data_valid, 3 stop_err, 4 strt_glitch
    typedef struct {
        int cyc;
        int kind;
        int bc;
        int sd;
    } ev_t;

    ev_t exp_q[$];
    ev_t act_q[$];

    task automatic check_eq(input string tag, input int got, input int expv);
        n_checks++;
        if (got !== expv) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, expv);
        end
    endtask

    // Record every output pulse with the cycle it was seen in.
    always @(negedge CLK) begin
        if (!RST) begin
            if (deser_enable)          act_q.push_back('{cyc, 0, int'(bit_cnt), int'(sampled_data)});
            if (parity_checker_enable) act_q.push_back('{cyc, 1, int'(bit_cnt), int'(sampled_data)});
            if (data_valid)            act_q.push_back('{cyc, 2, int'(bit_cnt), int'(sampled_data)});
            if (stop_err)              act_q.push_back('{cyc, 3, int'(bit_cnt), int'(sampled_data)});
            if (strt_glitch)           act_q.push_back('{cyc, 4, int'(bit_cnt), int'(sampled_data)});
        end
    end

    // Frame model: line start at cycle t; bit k ends (from the receiver's view) at t+(k+1)p.
    // Only bits k < lim are expected; the frame verdict only when the frame completes (lim >= 11).
    function automatic void expect_frame(input int t, input int p, input bit par, input logic [7:0] d,
                                         input bit pb, input bit sb, input bit perr, input int lim);
        int n;
        for (int k = 1; k <= 9; k++) begin
            if (k >= lim) break;
            if (k <= 8) exp_q.push_back('{t + (k + 1) * p, 0, k, int'(d[k-1])});
            if (par)    exp_q.push_back('{t + (k + 1) * p, 1, k, (k <= 8) ? int'(d[k-1]) : int'(pb)});
        end
        if (lim >= 11) begin
            n = par ? 11 : 10;
            if (!sb)               exp_q.push_back('{t + 1 + n * p, 3, 0, 0});
            else if (!(par && perr)) exp_q.push_back('{t + 1 + n * p, 2, 0, 1});
        end
    endfunction

    task automatic compare_events(input string tag);
        check_eq({tag, ".count"}, act_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < act_q.size(); i++) begin
            check_eq($sformatf("%s[%0d].cyc", tag, i),  act_q[i].cyc,  exp_q[i].cyc);
            check_eq($sformatf("%s[%0d].kind", tag, i), act_q[i].kind, exp_q[i].kind);
            check_eq($sformatf("%s[%0d].bc", tag, i),   act_q[i].bc,   exp_q[i].bc);
            check_eq($sformatf("%s[%0d].sd", tag, i),   act_q[i].sd,   exp_q[i].sd);
        end
        act_q.delete();
        exp_q.delete();
    endtask

    function automatic int rand_p();
        case ($urandom_range(0, 2))
            0:       return 8;
            1:       return 16;
            default: return 32;
        endcase
    endfunction

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge CLK);
            #1 RX_IN = 1'b1;
        end
    endtask

    // Drive one frame. gmask flips one oversample of selected data bits (must be voted away).
    // lim < 11 stops partway into line bit lim (half a bit time) for mid-frame reset tests.
    task automatic send_frame(input int p, input bit par, input logic [7:0] d, input bit pb, input bit sb,
                              input bit perr_drv, input logic [7:0] gmask, input int lim, output int t);
        logic bits [0:10];
        int   nb;
        int   ncyc;
        int   gpos;
        logic v;
        nb      = par ? 11 : 10;
        gpos    = p / 2 - 1 + $urandom_range(0, 2);
        bits[0] = 1'b0;
        for (int i = 1; i <= 8; i++) bits[i] = d[i-1];
        bits[9]  = par ? pb : sb;
        bits[10] = sb;
        t = 0;
        for (int b = 0; b < nb && b <= lim; b++) begin
            ncyc = (b == lim) ? p / 2 : p;
            for (int c = 0; c < ncyc; c++) begin
                @(posedge CLK);
                #1;
                if (b == 0 && c == 0) begin
                    t        = cyc;
                    PRESCALE = PW'(p);
                    PAR_EN   = par;
                end
                // Mid-frame config churn must not affect the frame already latched.
                if (b == 0 && c == 1) begin
                    PRESCALE = PW'(rand_p());
                    PAR_EN   = 1'($urandom);
                end
                if (b == 1 && c == 0) parity_err = perr_drv;
                v = bits[b];
                if (b >= 1 && b <= 8 && gmask[b-1] && c == gpos) v = ~v;
                RX_IN = v;
            end
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, ".bit_cnt"}, int'(bit_cnt), 0);
        check_eq({tag, ".sampled_data"}, int'(sampled_data), 1);
        check_eq({tag, ".pulses"}, int'({parity_checker_enable, deser_enable, data_valid, stop_err, strt_glitch}), 0);
    endtask

    initial begin
        int   t, t2, p;
        bit   par, pb, sb, perr;
        logic [7:0] d, gm;

        RST        = 1'b1;
        RX_IN      = 1'b1;
        PRESCALE   = PW'(8);
        PAR_EN     = 1'b0;
        parity_err = 1'b0;
        #12;
        check_reset_outputs("reset");
        @(posedge CLK);
        #1 RST = 1'b0;
        idle(5);

        // P=8, parity, 0xB3 with correct even parity bit.
        send_frame(8, 1, 8'hB3, 1, 1, 0, 8'h00, 11, t);
        expect_frame(t, 8, 1, 8'hB3, 1, 1, 0, 11);
        idle(6);
        compare_events("b3_good");

        // Same frame with wrong parity bit: checker flags, no verdict pulse.
        send_frame(8, 1, 8'hB3, 0, 1, 1, 8'h00, 11, t);
        expect_frame(t, 8, 1, 8'hB3, 0, 1, 1, 11);
        idle(6);
        compare_events("b3_bad_par");

        // P=16, no parity, bad stop; parity_err asserted but must be ignored.
        send_frame(16, 0, 8'h5A, 0, 0, 1, 8'h00, 11, t);
        expect_frame(t, 16, 0, 8'h5A, 0, 0, 1, 11);
        idle(20);
        compare_events("5a_stop_err");

        // Start glitch: line low two cycles only.
        @(posedge CLK);
        #1;
        t        = cyc;
        PRESCALE = PW'(8);
        RX_IN    = 1'b0;
        @(posedge CLK);
        #1 RX_IN = 1'b0;
        idle(16);
        exp_q.push_back('{t + 1 + 8, 4, 0, 1});
        compare_events("strt_glitch");

        // Back-to-back frames at P=32 with parity.
        send_frame(32, 1, 8'h3C, 0, 1, 0, 8'h00, 11, t);
        send_frame(32, 1, 8'hE1, 0, 1, 0, 8'h00, 11, t2);
        expect_frame(t, 32, 1, 8'h3C, 0, 1, 0, 11);
        expect_frame(t2, 32, 1, 8'hE1, 0, 1, 0, 11);
        idle(6);
        check_eq("b2b.gap", t2 - t, 352);
        compare_events("b2b");

        // Reset partway through data bit 5, then a clean frame.
        send_frame(8, 1, 8'h96, 0, 1, 0, 8'h00, 5, t);
        check_eq("midrst.bit_cnt_before", int'(bit_cnt), 5);
        expect_frame(t, 8, 1, 8'h96, 0, 1, 0, 5);
        #2 RST = 1'b1;
        #1;
        check_reset_outputs("midrst");
        @(posedge CLK);
        #1 RST   = 1'b0;
        RX_IN    = 1'b1;
        idle(4);
        compare_events("midrst_partial");
        send_frame(8, 1, 8'h96, 0, 1, 0, 8'h00, 11, t);
        expect_frame(t, 8, 1, 8'h96, 0, 1, 0, 11);
        idle(6);
        compare_events("after_rst");

        // Randomized frames: prescale, parity, data, errors, single-sample noise, back-to-back.
        for (int i = 0; i < 24; i++) begin
            p    = rand_p();
            par  = 1'($urandom);
            d    = 8'($urandom);
            pb   = (^d) ^ ($urandom_range(0, 5) == 0);
            sb   = ($urandom_range(0, 5) != 0);
            perr = par ? (pb != (^d)) : 1'($urandom);
            gm   = 8'($urandom) & 8'($urandom);
            send_frame(p, par, d, pb, sb, perr, gm, 11, t);
            expect_frame(t, p, par, d, pb, sb, perr, 11);
            if ($urandom_range(0, 1) == 0) begin
                idle(3 + $urandom_range(0, 4));
                compare_events($sformatf("rand%0d", i));
            end
        end
        idle(6);
        compare_events("rand_tail");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/uart_rx_fsm.md
Name: uart_rx_fsm

Overview:
Receive-side controller of the UART RX path; sits directly upstream of parity_checker and the deserializer. It detects the start bit, counts oversampling edges and bit positions, and majority-votes RX_IN around mid-bit. It drives bit_cnt, sampled_data and the per-bit enables that parity_checker consumes, then consumes parity_err to qualify the frame. Frame format: start(0), 8 data bits LSB first, optional parity, stop(1).

Parameters:
PRESCALE_WIDTH, 6, width of PRESCALE input; legal PRESCALE values 8, 16, 32

Ports:
CLK  input  1  system clock (oversampling clock)
RST  input  1  asynchronous, active-high reset
RX_IN  input  1  serial line, already synchronized to CLK; idles high
PRESCALE  input  PRESCALE_WIDTH  oversampling ratio
PAR_EN  input  1  1 = parity bit present in frame
parity_err  input  1  from parity_checker; registered, stable from cycle after parity-bit enable until next enable
bit_cnt  output  4  current bit: 0 start, 1..8 data, 9 parity (or stop if !PAR_EN), 10 stop
sampled_data  output  1  majority-voted value of current bit
parity_checker_enable  output  1  one-cycle pulse per bit for checker
deser_enable  output  1  one-cycle pulse per data bit for deserializer
data_valid  output  1  one-cycle pulse: frame good
stop_err  output  1  one-cycle pulse: stop bit sampled 0
strt_glitch  output  1  one-cycle pulse: start bit sampled 1

Behaviour:
- Reset (async, any time incl. mid-frame): state IDLE, edge_cnt 0, bit_cnt 0, sampled_data 1, all enables/pulses 0. Frame in progress discarded.
- All outputs registered. States: IDLE, START, DATA, PARITY, STOP.
- PRESCALE and PAR_EN latched on IDLE->START; changes mid-frame have no effect until next frame.
- edge_cnt: 0..P-1 (P = latched PRESCALE), increments every cycle outside IDLE, wraps to 0 at P-1; bit_cnt increments on that wrap.
- Sampling: RX_IN captured at edge_cnt P/2-2, P/2-1, P/2; sampled_data = majority of the three, updated the cycle after edge_cnt P/2; held until next bit's update.
- End-of-bit cycle = cycle with edge_cnt == P-1; enables are set when edge_cnt == P-2 so they are high exactly during end-of-bit, while bit_cnt still shows the current bit.
- parity_checker_enable: high at end-of-bit for bit_cnt 1..9 only when latched PAR_EN=1; never for start/stop; never when PAR_EN=0.
- deser_enable: high at end-of-bit for bit_cnt 1..8.
- IDLE: RX_IN==0 -> START next cycle with edge_cnt 0, bit_cnt 0.
- START end-of-bit: sampled_data 0 -> DATA; sampled_data 1 -> IDLE, strt_glitch pulses next cycle, no enables issued.
- DATA: after end-of-bit of bit_cnt 8 -> PARITY if PAR_EN else STOP.
- PARITY: end-of-bit -> STOP.
- STOP end-of-bit: evaluates sampled_data and parity_err (parity_err ignored when PAR_EN=0). data_valid pulses next cycle iff stop=1 and no parity error; stop_err pulses next cycle iff stop=0. Parity error with good stop: no data_valid, no stop_err.
- After STOP: RX_IN==0 on the end-of-bit cycle -> START directly (back-to-back frames, no idle cycle); otherwise IDLE.
- Latency: RX_IN falls at cycle T (sampled in IDLE) -> data_valid at T+1+11P with parity, T+1+10P without.
- RX_IN noise shorter than 2 of the 3 sample edges is rejected by the vote.

Test Plan:
- P=8, PAR_EN=1, even parity, byte 0xB3 (1,1,0,0,1,1,0,1), parity 1, stop 1 -> 9 parity_checker_enable pulses at bit_cnt 1..9, 8 deser_enable pulses, data_valid at T+89, stop_err 0.
- Same frame, parity bit 0 (checker raises parity_err) -> no data_valid, no stop_err, FSM returns IDLE.
- P=16, PAR_EN=0, byte 0x5A, stop 0 -> stop_err pulse at T+161, no data_valid, no parity_checker_enable pulses.
- P=8, RX_IN low for 2 cycles only (edge_cnt 0..1) -> strt_glitch pulse, back to IDLE, no enables.
- Two back-to-back frames, P=32, PAR_EN=1 -> second START entered without IDLE, two data_valid pulses 352 cycles apart.
- RST asserted at bit_cnt 5 -> outputs at reset values immediately; next valid frame received correctly.
